// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared widths, chip-enable levels and state encodings for the instruction fetch controller.
// Also holds the small helpers that word-align redirect targets.
package pc_fetch_ctrl_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    typedef logic [INST_ADDR_W-1:0] inst_addr_t;
    typedef logic [INST_W-1:0]      inst_t;

    localparam logic  CHIP_ENABLE  = 1'b1;
    localparam logic  CHIP_DISABLE = 1'b0;
    localparam inst_t ZERO_DWORD   = '0;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_FETCH = 2'b01;
    localparam logic [1:0] ST_HOLD  = 2'b10;

    function automatic inst_addr_t word_align(input inst_addr_t addr);
        return {addr[INST_ADDR_W-1:2], 2'b00};
    endfunction

    function automatic logic is_misaligned(input inst_addr_t addr);
        return |addr[1:0];
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, drives the instruction ROM and registers the IF/ID stage.
// Handles stall holds, delayed branches (with a one-entry pending target) and exception flushes.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter inst_addr_t RESET_PC = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       stall,
    input  logic       flush,
    input  inst_addr_t new_pc,
    input  logic       branch_flag,
    input  inst_addr_t branch_target,
    output logic       rom_ce,
    output inst_addr_t rom_addr,
    input  inst_t      rom_inst,
    output inst_addr_t if_pc,
    output inst_t      if_inst,
    output logic       if_valid,
    output logic       addr_err
);

    logic [1:0] state;
    inst_addr_t pc;
    logic       pend_valid;
    inst_addr_t pend_target;
    logic       redir_valid;
    inst_addr_t redir_target;

    assign rom_addr = pc;
    assign rom_ce   = (state == ST_IDLE) ? CHIP_DISABLE : CHIP_ENABLE;

    // A branch parked during a stall outranks a fresh branch_flag in the same cycle.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        redir_valid  = 1'b0;
        redir_target = branch_target;
        if (pend_valid) begin
            redir_valid  = 1'b1;
            redir_target = pend_target;
        end else if (branch_flag) begin
            redir_valid  = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            pend_valid  <= 1'b0;
            pend_target <= '0;
            if_pc       <= '0;
            if_inst     <= ZERO_DWORD;
            if_valid    <= 1'b0;
            addr_err    <= 1'b0;
        end else begin
            addr_err <= 1'b0;
            if (flush) begin
                state      <= ST_FETCH;
                pc         <= word_align(new_pc);
                addr_err   <= is_misaligned(new_pc);
                if_valid   <= 1'b0;
                if_inst    <= ZERO_DWORD;
                pend_valid <= 1'b0;
            end else if (state == ST_IDLE) begin
                state <= ST_FETCH;
                if (stall && branch_flag) begin
                    pend_valid  <= 1'b1;
                    pend_target <= branch_target;
                end
            end else if (stall) begin
                // PC and IF/ID stay frozen; a branch seen now is parked until the stall clears.
                state <= ST_HOLD;
                if (branch_flag) begin
                    pend_valid  <= 1'b1;
                    pend_target <= branch_target;
                end
            end else begin
                state      <= ST_FETCH;
                if_pc      <= pc;
                if_inst    <= rom_inst;
                if_valid   <= 1'b1;
                pend_valid <= 1'b0;
                if (redir_valid) begin
                    pc       <= word_align(redir_target);
                    addr_err <= is_misaligned(redir_target);
                end else begin
                    pc <= pc + 32'd4;
                end
            end
        end
    end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-004 SHALL have port stall, input, 1, meaning the pipeline controller requests a fetch hold.
REQ-005 SHALL have port flush, input, 1, meaning exception redirect to new_pc.
REQ-006 SHALL have port new_pc, input, `INST_ADDR_BUS, meaning the exception target.
REQ-007 SHALL have port branch_flag, input, 1, meaning the decode-stage branch is taken.
REQ-008 SHALL have port branch_target, input, `INST_ADDR_BUS, meaning the taken-branch target.
REQ-009 SHALL have port rom_ce, output, 1, meaning instruction ROM chip enable (`CHIP_ENABLE/`CHIP_DISABLE).
REQ-010 SHALL have port rom_addr, output, `INST_ADDR_BUS, meaning the ROM byte address.
REQ-011 SHALL have port rom_inst, input, `INST_BUS, meaning the combinational ROM data for rom_addr.
REQ-012 SHALL have ports if_pc (`INST_ADDR_BUS), if_inst (`INST_BUS) and if_valid (1), all outputs, meaning the registered IF/ID stage.
REQ-013 SHALL have port addr_err, output, 1, meaning a one-cycle pulse when a redirect target is misaligned.

Function
REQ-014 SHALL implement the states IDLE, FETCH and HOLD.
REQ-015 SHALL assign rom_addr = pc and rom_ce = `CHIP_ENABLE only in FETCH/HOLD; in IDLE rom_ce = `CHIP_DISABLE.
REQ-016 SHALL move IDLE->FETCH unconditionally one cycle after reset release, with pc = RESET_PC.
REQ-017 SHALL, in FETCH with no stall/flush/branch, load if_pc<=pc, if_inst<=rom_inst, if_valid<=1 and pc<=pc+4; the ROM-to-IF/ID latency is 1 cycle.
REQ-018 SHALL give pc updates the priority flush > stall > pending branch > branch_flag > sequential.
REQ-019 SHALL, on flush in any state, set pc<=new_pc, if_valid<=0, clear the pending branch and enter FETCH.
REQ-020 SHALL, on stall in FETCH, enter HOLD; in HOLD, pc and all if_* outputs are frozen; HOLD->FETCH when stall deasserts.
REQ-021 SHALL, on branch_flag in FETCH without stall, capture the current instruction (the delay slot) into IF/ID normally and set pc<=branch_target.
REQ-022 SHALL, on branch_flag while stall is high, latch branch_target into a one-entry pending register; on the first non-stall cycle, pc<=pending target and the pending register clears; a second branch_flag during the same stall overwrites the pending target.
REQ-023 SHALL, when a redirect target (new_pc or branch) has bits[1:0] != 0, clear those bits in pc and pulse addr_err high for one cycle.
REQ-024 SHALL let pc wrap from 32'hFFFF_FFFC to 32'h0000_0000 with no error.
REQ-025 SHALL, when flush and stall are asserted in the same cycle, perform the flush and enter FETCH (not HOLD).
REQ-026 SHALL drive if_inst to `ZERO_DWORD whenever if_valid is 0.

Reset
REQ-027 SHALL, while rst_n=0: state=IDLE, pc=RESET_PC, rom_ce=`CHIP_DISABLE, if_pc=0, if_inst=`ZERO_DWORD, if_valid=0, addr_err=0, pending branch cleared.
REQ-028 SHALL, on reset asserted mid-operation, discard all pending state immediately (asynchronously), and restart at RESET_PC after release.

Structure
REQ-029 SHALL take bus widths, `CHIP_ENABLE/`CHIP_DISABLE and `ZERO_DWORD from defines.v; the state encodings (2-bit) are added there as well.
REQ-030 SHALL be a single module with no sub-modules; it connects directly to inst_rom at the top level.

Verification
REQ-031 SHALL cover: release reset with RESET_PC=0 -> rom_ce low for 1 cycle, then if_pc sequence 0,4,8 with if_valid=1 from the 2nd fetch edge.
REQ-032 SHALL cover: stall high for 3 cycles at pc=0x10 -> if_pc held at 0xC, rom_addr held at 0x10, and 0x10 is fetched after release.
REQ-033 SHALL cover: branch_flag with target 0x100 while fetching 0x14 -> if_pc 0x14 (delay slot), then 0x100.
REQ-034 SHALL cover: branch_flag(0x200) during stall, then stall drops -> next rom_addr=0x200, and the pending register is cleared.
REQ-035 SHALL cover: flush+stall together with new_pc=0x182 -> rom_addr=0x180, addr_err pulse, if_valid=0, state FETCH.
REQ-036 SHALL cover: rst_n asserted mid-stream -> all outputs reach their reset values without waiting for a clock edge.
